// File: rtl/score_bcd_keeper_pkg.sv
// Shared constants and types for the BCD score keeper: point table defaults,
// digit geometry, the saturation value and the FSM state encoding.
package score_bcd_keeper_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SCORE_W    = DIGIT_W * NUM_DIGITS;
  localparam int unsigned PEND_W     = 4;
  localparam int unsigned LINES_W    = 3;

  // Default points awarded per number of lines cleared.
  localparam int unsigned PTS1 = 1;
  localparam int unsigned PTS2 = 3;
  localparam int unsigned PTS3 = 5;
  localparam int unsigned PTS4 = 8;

  // 9999 in packed BCD, thousands digit in the top nibble.
  localparam logic [SCORE_W-1:0] SCORE_SAT_BCD = 16'h9999;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_e;

  // Points for a clear event; 0 lines and the illegal codes 5..7 score nothing.
  function automatic logic [PEND_W-1:0] pts_lookup(
    input logic [LINES_W-1:0] lines,
    input logic [PEND_W-1:0]  p1,
    input logic [PEND_W-1:0]  p2,
    input logic [PEND_W-1:0]  p3,
    input logic [PEND_W-1:0]  p4
  );
    logic [PEND_W-1:0] pts;
    case (lines)
      3'd1:    pts = p1;
      3'd2:    pts = p2;
      3'd3:    pts = p3;
      3'd4:    pts = p4;
      default: pts = '0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_bcd_keeper_bcd_digit_inc.sv
// Single BCD digit conditional incrementer (combinational).
//   digit      : current BCD digit 0..9
//   carry_in   : add one to this digit
//   digit_next : resulting BCD digit
//   carry_out  : digit wrapped 9 -> 0, propagate to the next digit
module bcd_digit_inc
  import score_bcd_keeper_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               carry_out
);

  always_comb begin
    digit_next = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (digit >= DIGIT_W'(9)) begin
        digit_next = '0;
        carry_out  = 1'b1;
      end else begin
        digit_next = digit + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_bcd_keeper.sv
// Four-digit BCD score keeper. Accepts one line-clear event at a time over a
// valid/ready handshake and adds its points one per clock, saturating at 9999.
//   clk, rst            : clock, synchronous active-high reset
//   pause               : freezes the adder and blocks acceptance
//   clear_valid/_lines  : line-clear event (lines 0..4, 5..7 score nothing)
//   clear_ready         : event can be accepted this cycle
//   score1..score4      : BCD ones..thousands digits
//   score_sat           : score has reached 9999
//   score_tick          : one-cycle pulse per single-point increment
module score_bcd_keeper
  import score_bcd_keeper_pkg::*;
#(
  parameter int unsigned PTS1 = score_bcd_keeper_pkg::PTS1,
  parameter int unsigned PTS2 = score_bcd_keeper_pkg::PTS2,
  parameter int unsigned PTS3 = score_bcd_keeper_pkg::PTS3,
  parameter int unsigned PTS4 = score_bcd_keeper_pkg::PTS4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               clear_valid,
  input  logic [LINES_W-1:0] clear_lines,
  output logic               clear_ready,
  output logic [DIGIT_W-1:0] score1,
  output logic [DIGIT_W-1:0] score2,
  output logic [DIGIT_W-1:0] score3,
  output logic [DIGIT_W-1:0] score4,
  output logic               score_sat,
  output logic               score_tick
);

  state_e                                 state;
  logic [PEND_W-1:0]                      pend;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     score_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     score_inc;
  logic [NUM_DIGITS:0]                    carry;
  logic [PEND_W-1:0]                      pts;
  logic                                   at_max;

  // Ripple chain computing score+1 in a single cycle.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_inc u_inc (
      .digit      (score_q[i]),
      .carry_in   (carry[i]),
      .digit_next (score_inc[i]),
      .carry_out  (carry[i+1])
    );
  end

  assign at_max = (score_q == SCORE_SAT_BCD);
  assign pts    = pts_lookup(clear_lines, PEND_W'(PTS1), PEND_W'(PTS2),
                             PEND_W'(PTS3), PEND_W'(PTS4));

  // Ready must drop in the same cycle pause rises, so it is decoded from state.
  assign clear_ready = (state == ST_IDLE) && !pause;

  // FSM, pending-points counter and score registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend       <= '0;
      score_q    <= '0;
      score_sat  <= 1'b0;
      score_tick <= 1'b0;
    end else begin
      score_tick <= 1'b0;
      if (!pause) begin
        case (state)
          ST_IDLE: begin
            if (clear_valid) begin
              pend <= pts;
              if (pts != '0) state <= ST_ADD;
            end
          end
          ST_ADD: begin
            if (!at_max) begin
              score_q    <= score_inc;
              score_tick <= 1'b1;
              score_sat  <= (score_inc == SCORE_SAT_BCD);
            end
            pend <= pend - PEND_W'(1);
            if (pend == PEND_W'(1)) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign score1 = score_q[0];
  assign score2 = score_q[1];
  assign score3 = score_q[2];
  assign score4 = score_q[3];

endmodule

// File: tb/tb_score_bcd_keeper.sv
// Self-checking bench for score_bcd_keeper: integer reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_score_bcd_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       clear_valid = 1'b0;
  logic [2:0] clear_lines = 3'd0;
  logic       clear_ready;
  logic [3:0] score1, score2, score3, score4;
  logic       score_sat, score_tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  bit check_en = 1'b0;

  // Reference model state: score as a plain integer.
  int m_score = 0;
  int m_rem = 0;
  bit m_busy = 1'b0;
  bit m_tick = 1'b0;

  always #5 clk = ~clk;

  score_bcd_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .clear_ready (clear_ready),
    .score1      (score1),
    .score2      (score2),
    .score3      (score3),
    .score4      (score4),
    .score_sat   (score_sat),
    .score_tick  (score_tick)
  );

  function automatic int pts_of(input logic [2:0] l);
    case (l)
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_score <= 0; m_rem <= 0; m_busy <= 1'b0; m_tick <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      if (!pause) begin
        if (!m_busy) begin
          if (clear_valid) begin
            m_rem  <= pts_of(clear_lines);
            m_busy <= (pts_of(clear_lines) != 0);
          end
        end else begin
          if (m_score < 9999) begin
            m_score <= m_score + 1;
            m_tick  <= 1'b1;
          end
          m_rem <= m_rem - 1;
          if (m_rem == 1) m_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("score", {score4, score3, score2, score1}, to_bcd(m_score));
        check("score_sat", 16'(score_sat), 16'(m_score == 9999));
        check("score_tick", 16'(score_tick), 16'(m_tick));
        check("clear_ready", 16'(clear_ready), 16'(!m_busy && !pause));
        if (score_tick) tick_cnt++;
      end
    end
  end

  // Present an event and hold it until accepted; returns just after the accept edge.
  task automatic accept(input logic [2:0] l);
    int n = 0;
    @(posedge clk); #1;
    clear_valid = 1'b1; clear_lines = l;
    @(negedge clk);
    while (!clear_ready && n < 200) begin @(negedge clk); n++; end
    if (!clear_ready) check("accept_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    clear_valid = 1'b0;
  endtask

  // Count cycles with ready low until the block is idle again.
  task automatic wait_idle(output int busy);
    busy = 0;
    @(negedge clk);
    while (!clear_ready && busy < 50) begin busy++; @(negedge clk); end
    if (!clear_ready) check("idle_timeout", 16'd0, 16'd1);
  endtask

  task automatic drive_to(input int target);
    int b;
    while (m_score < target) begin
      if (target - m_score >= 8) accept(3'd4);
      else if (target - m_score >= 5) accept(3'd3);
      else if (target - m_score >= 3) accept(3'd2);
      else accept(3'd1);
      wait_idle(b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    int t0, b;
    do_reset();
    check_en = 1'b1;
    @(negedge clk);
    check("reset_score", {score4, score3, score2, score1}, 16'h0000);
    check("reset_ready", 16'(clear_ready), 16'd1);

    // Single point: first increment two cycles after acceptance.
    t0 = tick_cnt;
    accept(3'd1);
    @(negedge clk);
    check("lat_n1_score", {score4, score3, score2, score1}, 16'h0000);
    check("lat_n1_ready", 16'(clear_ready), 16'd0);
    @(negedge clk);
    check("lat_n2_score", {score4, score3, score2, score1}, 16'h0001);
    check("lat_n2_ready", 16'(clear_ready), 16'd1);
    check("lat_ticks", 16'(tick_cnt - t0), 16'd1);

    // 1 + 3 + 3 = 7, then 8 points crossing into the tens.
    accept(3'd2); wait_idle(b);
    accept(3'd2); wait_idle(b);
    check("preset7", {score4, score3, score2, score1}, 16'h0007);
    t0 = tick_cnt;
    accept(3'd4); wait_idle(b);
    check("to15_score", {score4, score3, score2, score1}, 16'h0015);
    check("to15_ticks", 16'(tick_cnt - t0), 16'd8);
    check("to15_busy", 16'(b), 16'd8);

    // Triple carry 0999 -> 1000.
    drive_to(998);
    check("preset998", {score4, score3, score2, score1}, 16'h0998);
    accept(3'd2); wait_idle(b);
    check("to1001", {score4, score3, score2, score1}, 16'h1001);

    // Saturation.
    drive_to(9996);
    t0 = tick_cnt;
    accept(3'd4); wait_idle(b);
    check("sat_score", {score4, score3, score2, score1}, 16'h9999);
    check("sat_flag", 16'(score_sat), 16'd1);
    check("sat_ticks", 16'(tick_cnt - t0), 16'd3);
    check("sat_busy", 16'(b), 16'd8);
    t0 = tick_cnt;
    accept(3'd1); wait_idle(b);
    check("sat_hold", {score4, score3, score2, score1}, 16'h9999);
    check("sat_noticks", 16'(tick_cnt - t0), 16'd0);

    // Mid-ADD pause for five cycles.
    do_reset();
    t0 = tick_cnt;
    accept(3'd4);
    @(posedge clk);
    @(posedge clk); #1; pause = 1'b1;
    repeat (5) @(negedge clk);
    check("pause_frozen", {score4, score3, score2, score1}, 16'h0002);
    check("pause_ready", 16'(clear_ready), 16'd0);
    @(posedge clk); #1; pause = 1'b0;
    wait_idle(b);
    check("pause_score", {score4, score3, score2, score1}, 16'h0008);
    check("pause_ticks", 16'(tick_cnt - t0), 16'd8);

    // Valid while paused in IDLE is not accepted.
    @(posedge clk); #1; pause = 1'b1; clear_valid = 1'b1; clear_lines = 3'd4;
    repeat (3) @(negedge clk);
    check("idle_pause_ready", 16'(clear_ready), 16'd0);
    @(posedge clk); #1; clear_valid = 1'b0;
    @(posedge clk); #1; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_pause_score", {score4, score3, score2, score1}, 16'h0008);

    // Zero-point events are consumed in one cycle.
    t0 = tick_cnt;
    accept(3'd0); wait_idle(b);
    check("lines0_busy", 16'(b), 16'd0);
    accept(3'd6); wait_idle(b);
    check("lines6_busy", 16'(b), 16'd0);
    check("lines06_score", {score4, score3, score2, score1}, 16'h0008);
    check("lines06_ticks", 16'(tick_cnt - t0), 16'd0);

    // Reset mid-ADD discards the remaining points.
    accept(3'd4);
    @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_mid_score", {score4, score3, score2, score1}, 16'h0000);
    check("rst_mid_ready", 16'(clear_ready), 16'd1);
    repeat (12) @(negedge clk);
    check("rst_mid_stay", {score4, score3, score2, score1}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
